// File: rtl/regfile_tester_pkg.sv
// Shared types and constants for the register-file self-tester.
package regfile_tester_pkg;

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned ERR_W    = 6;
   localparam int unsigned LED_W    = 8;

   localparam logic [DATA_W-1:0] DEFAULT_SEED = 32'h1234_5678;
   localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NUM_REGS - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX      = ERR_W'(NUM_REGS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Test word stored at a given address: seed plus address, modulo 2^32.
   function automatic logic [DATA_W-1:0] pattern_word(input logic [DATA_W-1:0] seed,
                                                      input logic [ADDR_W-1:0] addr);
      return seed + DATA_W'(addr);
   endfunction

endpackage

// File: rtl/regfile_tester_cmp.sv
// Expected-pattern generation and read-data comparison for one read port.
module regfile_tester_cmp
   import regfile_tester_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED = DEFAULT_SEED
)(
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_mismatch_c
);

   logic [DATA_W-1:0] w_expect;

   // Flag any difference between the read word and the pattern for its address.
   always_comb begin
      w_expect     = pattern_word(SEED, i_addr);
      o_mismatch_c = (i_data != w_expect);
   end

endmodule

// File: rtl/regfile_tester.sv
// Register-file self-tester: writes SEED+addr to all 32 registers, reads them
// back and reports error count, first failing address and pass/fail.
// Optional port-B checking is compiled in with REGFILE_TESTER_BCHECK_EN.
module regfile_tester
   import regfile_tester_pkg::*;
#(
   parameter logic [DATA_W-1:0] SEED = DEFAULT_SEED
)(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   output logic              Write_Reg,
   output logic [ADDR_W-1:0] W_Addr,
   output logic [DATA_W-1:0] W_Data,
   output logic [ADDR_W-1:0] R_Addr_A,
   output logic [ADDR_W-1:0] R_Addr_B,
   input  logic [DATA_W-1:0] R_Data_A,
   input  logic [DATA_W-1:0] R_Data_B,
   output logic              Busy,
   output logic              Done,
   output logic              Pass,
   output logic [ADDR_W-1:0] Fail_Addr,
   output logic [LED_W-1:0]  LED
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ERR_W-1:0]  r_err_cnt;

   state_t            w_state_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [ERR_W-1:0]  w_err_nxt;
   logic [ADDR_W-1:0] w_fail_nxt;
   logic              w_pass_nxt;
   logic              w_done_nxt;
   logic              w_wr_nxt;
   logic              w_rd_nxt;
   logic [ADDR_W-1:0] w_waddr_nxt;
   logic [DATA_W-1:0] w_wdata_nxt;
   logic [ADDR_W-1:0] w_raddr_a_nxt;
   logic [ADDR_W-1:0] w_raddr_b_nxt;
   logic              w_last;
   logic              w_mis_a;
   logic              w_mis_b;

   regfile_tester_cmp #(.SEED(SEED)) u_cmp_a (
      .i_addr       (R_Addr_A),
      .i_data       (R_Data_A),
      .o_mismatch_c (w_mis_a)
   );

`ifdef REGFILE_TESTER_BCHECK_EN
   localparam bit BCHECK_EN = 1'b1;

   regfile_tester_cmp #(.SEED(SEED)) u_cmp_b (
      .i_addr       (R_Addr_B),
      .i_data       (R_Data_B),
      .o_mismatch_c (w_mis_b)
   );
`else
   localparam bit BCHECK_EN = 1'b0;

   logic w_unused_data_b;

   // Port B is not checked in this build; its read data is deliberately dropped.
   assign w_mis_b         = 1'b0;
   assign w_unused_data_b = ^R_Data_B;
`endif

   assign w_last = (r_addr == LAST_ADDR);
   assign LED    = {2'b00, r_err_cnt};

   // Next state, counters and the registered-output values for the next cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_err_nxt   = r_err_cnt;
      w_fail_nxt  = Fail_Addr;
      w_pass_nxt  = Pass;
      w_done_nxt  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_state_nxt = S_WRITE;
               w_addr_nxt  = '0;
               w_err_nxt   = '0;
               w_fail_nxt  = '0;
               w_pass_nxt  = 1'b0;
            end
         end
         S_WRITE: begin
            w_addr_nxt = r_addr + ADDR_W'(1);
            if (w_last) begin
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (w_mis_a || w_mis_b) begin
               // Only the first failing cycle records an address; A wins ties.
               if (r_err_cnt == '0) begin
                  w_fail_nxt = w_mis_a ? R_Addr_A : R_Addr_B;
               end
               if (r_err_cnt != ERR_MAX) begin
                  w_err_nxt = r_err_cnt + ERR_W'(1);
               end
            end
            w_addr_nxt = r_addr + ADDR_W'(1);
            if (w_last) begin
               w_state_nxt = S_DONE;
               w_done_nxt  = 1'b1;
               w_pass_nxt  = (w_err_nxt == '0);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Bus outputs are derived from the state being entered so they are registered.
      w_wr_nxt      = (w_state_nxt == S_WRITE);
      w_rd_nxt      = (w_state_nxt == S_READ);
      w_waddr_nxt   = w_wr_nxt ? w_addr_nxt : '0;
      w_wdata_nxt   = w_wr_nxt ? pattern_word(SEED, w_addr_nxt) : '0;
      w_raddr_a_nxt = w_rd_nxt ? w_addr_nxt : '0;
      w_raddr_b_nxt = (w_rd_nxt && BCHECK_EN) ? (LAST_ADDR - w_addr_nxt) : '0;
   end

   // State, counters and outputs; synchronous reset clears everything.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_err_cnt <= '0;
         Write_Reg <= 1'b0;
         W_Addr    <= '0;
         W_Data    <= '0;
         R_Addr_A  <= '0;
         R_Addr_B  <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Pass      <= 1'b0;
         Fail_Addr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_err_cnt <= w_err_nxt;
         Write_Reg <= w_wr_nxt;
         W_Addr    <= w_waddr_nxt;
         W_Data    <= w_wdata_nxt;
         R_Addr_A  <= w_raddr_a_nxt;
         R_Addr_B  <= w_raddr_b_nxt;
         Busy      <= w_wr_nxt | w_rd_nxt;
         Done      <= w_done_nxt;
         Pass      <= w_pass_nxt;
         Fail_Addr <= w_fail_nxt;
      end
   end

endmodule
